// File: rtl/sobol_seq_ctrl.sv
// Sobol RNG sequencer: holds the direction-vector array, counts samples
// for a run and drives the RNG's index pair and reset.
module sobol_seq_ctrl #(
    parameter int INWD     = 8,
    parameter int LOGINWD  = 3,
    parameter int IDX1_REV = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [LOGINWD-1:0]         cfg_addr,
    input  logic [INWD:0]              cfg_data,
    input  logic                       start,
    input  logic [INWD:0]              len,
    input  logic                       abort,
    output logic                       busy,
    output logic                       done,
    output logic                       sample_valid,
    output logic [LOGINWD-1:0]         vec_idx_0,
    output logic [LOGINWD-1:0]         vec_idx_1,
    output logic [INWD*(INWD+1)-1:0]   dir_vec,
    output logic                       rng_rst_n
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    localparam logic [INWD:0] MAXLEN = {1'b1, {INWD{1'b0}}};

    state_e        state_q, state_d;
    logic [INWD:0] k_q, k_d;
    logic [INWD:0] len_q, len_d;
    logic          rng_rst_q, rng_rst_d;
    logic [INWD:0] vec_q [INWD];

    logic [INWD:0]      len_clamp;
    logic [LOGINWD-1:0] lsz;
    logic               cfg_we;
    logic               run;

    assign run       = (state_q == S_RUN);
    assign cfg_ready = rst_n && (state_q == S_IDLE);
    assign cfg_we    = cfg_valid && cfg_ready;
    assign len_clamp = (len > MAXLEN) ? MAXLEN : len;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < INWD; i++) begin
                vec_q[i] <= '0;
            end
        end else if (cfg_we) begin
            vec_q[cfg_addr] <= cfg_data;
        end
    end

    always_comb begin
        dir_vec = '0;
        for (int i = 0; i < INWD; i++) begin
            dir_vec[i*(INWD+1) +: INWD+1] = vec_q[i];
        end
    end

    // Lowest zero bit of k; all-ones saturates to the top entry.
    always_comb begin
        lsz = LOGINWD'(INWD - 1);
        for (int i = INWD - 1; i >= 0; i--) begin
            if (!k_q[i]) begin
                lsz = LOGINWD'(i);
            end
        end
    end

    assign vec_idx_0 = run ? lsz : '0;
    assign vec_idx_1 = !run ? '0 :
                       (IDX1_REV != 0) ? (LOGINWD'(INWD - 1) - lsz) : lsz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            len_q     <= '0;
            rng_rst_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            len_q     <= len_d;
            rng_rst_q <= rng_rst_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        len_d     = len_q;
        rng_rst_d = rng_rst_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d = len_clamp;
                    k_d   = '0;
                    if (len_clamp == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d   = S_RUN;
                        rng_rst_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d   = S_IDLE;
                    rng_rst_d = 1'b0;
                end else begin
                    k_d = k_q + 1'b1;
                    if (k_q == len_q - 1'b1) begin
                        state_d   = S_DONE;
                        rng_rst_d = 1'b0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                rng_rst_d = 1'b0;
            end
        endcase
    end

    assign busy         = (state_q == S_RUN) || (state_q == S_DONE);
    assign done         = (state_q == S_DONE);
    assign sample_valid = run;
    assign rng_rst_n    = rng_rst_q;

endmodule

// File: tb/tb_sobol_seq_ctrl.sv
// Bench for sobol_seq_ctrl with a stand-in two-stream RNG and a
// Gray-code Sobol reference for the expected samples.
module tb_sobol_seq_ctrl;

    localparam int INWD    = 8;
    localparam int LOGINWD = 3;
    localparam int REV     = 0;
    localparam int EW      = INWD + 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 cfg_valid = 1'b0;
    logic                 cfg_ready;
    logic [LOGINWD-1:0]   cfg_addr = '0;
    logic [EW-1:0]        cfg_data = '0;
    logic                 start = 1'b0;
    logic [EW-1:0]        len = '0;
    logic                 abort = 1'b0;
    logic                 busy, done, sample_valid, rng_rst_n;
    logic [LOGINWD-1:0]   vi0, vi1;
    logic [INWD*EW-1:0]   dir_vec;

    sobol_seq_ctrl #(.INWD(INWD), .LOGINWD(LOGINWD), .IDX1_REV(REV)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .start(start), .len(len), .abort(abort),
        .busy(busy), .done(done), .sample_valid(sample_valid),
        .vec_idx_0(vi0), .vec_idx_1(vi1),
        .dir_vec(dir_vec), .rng_rst_n(rng_rst_n)
    );

    always #5 clk = ~clk;

    // Stand-in RNG stream 0: iterative Sobol update, sample is x[INWD:1].
    logic [EW-1:0] acc;
    always_ff @(posedge clk or negedge rng_rst_n) begin
        if (!rng_rst_n) acc <= '0;
        else            acc <= acc ^ dir_vec[vi0*EW +: EW];
    end

    int nvec = 0;
    int nbad = 0;
    logic [EW-1:0] mv [INWD];
    bit plan_mode = 1'b0;
    logic [INWD-1:0] plan_x [8] = '{8'h00, 8'h80, 8'hC0, 8'h40,
                                    8'h60, 8'hE0, 8'hA0, 8'h20};

    typedef struct {
        int len;
        int ab;
        bit abdone;
        int exp_n;
        int exp_d;
    } vec_t;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_idx(input int k);
        int t = 0;
        while (t < INWD && ((k >> t) & 1) == 1) t++;
        return (t >= INWD) ? INWD - 1 : t;
    endfunction

    function automatic logic [EW-1:0] exp_x(input int k);
        int g = k ^ (k >> 1);
        logic [EW-1:0] x = '0;
        for (int i = 0; i < INWD; i++)
            if (((g >> i) & 1) == 1) x = x ^ mv[i];
        return x;
    endfunction

    task automatic wr(input int a, input logic [EW-1:0] d);
        cfg_valid = 1'b1;
        cfg_addr  = LOGINWD'(a);
        cfg_data  = d;
        chk("cfg_ready_idle", 128'(cfg_ready), 128'(1));
        cyc();
        cfg_valid = 1'b0;
        mv[a] = d;
    endtask

    task automatic chk_vecs();
        for (int i = 0; i < INWD; i++)
            chk("dir_vec", 128'(dir_vec[i*EW +: EW]), 128'(mv[i]));
    endtask

    task automatic run(input int l, input int ab, input bit abdone,
                       input int exp_n, input int exp_d);
        int k = 0;
        int dn = 0;
        bit rs = 1'b0;
        logic [EW-1:0] x;
        int ei;
        start = 1'b1;
        len   = EW'(l);
        cyc();
        start     = 1'b0;
        cfg_valid = 1'b0;
        for (int c = 0; c < 400 && busy === 1'b1; c++) begin
            if (sample_valid === 1'b1) begin
                ei = exp_idx(k);
                x  = exp_x(k);
                chk("vec_idx_0", 128'(vi0), 128'(ei));
                chk("vec_idx_1", 128'(vi1),
                    128'((REV != 0) ? INWD - 1 - ei : ei));
                chk("sample", 128'(acc[INWD:1]), 128'(x[INWD:1]));
                if (plan_mode && k < 8)
                    chk("plan_stream", 128'(acc[INWD:1]), 128'(plan_x[k]));
                if (k == ab) abort = 1'b1;
                k++;
            end
            if (done === 1'b1) begin
                dn++;
                if (abdone) abort = 1'b1;
            end
            if (rng_rst_n === 1'b1) rs = 1'b1;
            cyc();
            abort = 1'b0;
        end
        chk("run_cycles", 128'(k), 128'(exp_n));
        chk("done_pulses", 128'(dn), 128'(exp_d));
        chk("idle_after_run", 128'(busy), 128'(0));
        chk("rng_rst_n_after", 128'(rng_rst_n), 128'(0));
        if (exp_n == 0) chk("rng_rst_n_len0", 128'(rs), 128'(0));
    endtask

    vec_t tbl[10];

    initial begin
        int l, ab, n, en, ed;
        tbl = '{
            '{8,   -1, 1'b0, 8,   1},
            '{0,   -1, 1'b0, 0,   1},
            '{0,   -1, 1'b1, 0,   1},
            '{256, -1, 1'b0, 256, 1},
            '{300, -1, 1'b0, 256, 1},
            '{8,    3, 1'b0, 4,   0},
            '{8,   -1, 1'b0, 8,   1},
            '{5,    4, 1'b0, 5,   0},
            '{1,   -1, 1'b0, 1,   1},
            '{257, -1, 1'b1, 256, 1}
        };
        for (int i = 0; i < INWD; i++) mv[i] = '0;

        #2;
        chk("rst_cfg_ready", 128'(cfg_ready), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_sample_valid", 128'(sample_valid), 128'(0));
        chk("rst_rng_rst_n", 128'(rng_rst_n), 128'(0));
        chk("rst_vec_idx_0", 128'(vi0), 128'(0));
        chk_vecs();
        #10 rst_n = 1'b1;
        cyc();
        chk("cfg_ready_after_rst", 128'(cfg_ready), 128'(1));
        chk("busy_after_rst", 128'(busy), 128'(0));

        for (int i = 0; i < INWD; i++) wr(i, EW'(9'h100 >> i));
        chk_vecs();

        for (int i = 0; i < 10; i++) begin
            plan_mode = (i == 0);
            run(tbl[i].len, tbl[i].ab, tbl[i].abdone,
                tbl[i].exp_n, tbl[i].exp_d);
        end
        plan_mode = 1'b0;

        start = 1'b1;
        len   = EW'(8);
        cyc();
        start     = 1'b0;
        cfg_valid = 1'b1;
        cfg_addr  = '0;
        cfg_data  = ~mv[0];
        chk("cfg_ready_run", 128'(cfg_ready), 128'(0));
        for (int c = 0; c < 5; c++) cyc();
        cfg_valid = 1'b0;
        chk_vecs();
        for (int c = 0; c < 20 && busy === 1'b1; c++) cyc();
        chk("idle_after_cfg_run", 128'(busy), 128'(0));
        chk_vecs();

        cfg_valid = 1'b1;
        cfg_addr  = '0;
        cfg_data  = 9'h0F0;
        mv[0]     = 9'h0F0;
        run(4, -1, 1'b0, 4, 1);
        chk_vecs();

        for (int it = 0; it < 20; it++) begin
            wr($urandom_range(0, INWD - 1), EW'($urandom));
            l  = $urandom_range(0, 300);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, l) : -1;
            n  = (l > 256) ? 256 : l;
            if (ab >= 0 && ab < n) begin
                en = ab + 1;
                ed = 0;
            end else begin
                en = n;
                ed = 1;
            end
            run(l, ab, 1'b0, en, ed);
        end
        chk_vecs();

        start = 1'b1;
        len   = EW'(8);
        cyc();
        start = 1'b0;
        for (int c = 0; c < 5; c++) cyc();
        chk("pre_rst_vec_idx_0", 128'(vi0), 128'(exp_idx(5)));
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < INWD; i++) mv[i] = '0;
        chk("mid_rst_cfg_ready", 128'(cfg_ready), 128'(0));
        chk("mid_rst_busy", 128'(busy), 128'(0));
        chk("mid_rst_done", 128'(done), 128'(0));
        chk("mid_rst_sample_valid", 128'(sample_valid), 128'(0));
        chk("mid_rst_vec_idx_0", 128'(vi0), 128'(0));
        chk("mid_rst_vec_idx_1", 128'(vi1), 128'(0));
        chk("mid_rst_rng_rst_n", 128'(rng_rst_n), 128'(0));
        chk_vecs();
        #3 rst_n = 1'b1;
        #1;
        chk("rel_cfg_ready", 128'(cfg_ready), 128'(1));
        chk("rel_busy", 128'(busy), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
